adc_multi_rx: RTL and testbench

ADC_MULTI_RX -- requirements
Module: adc_multi_rx

---
 rtl/adc_rx_pkg.sv | 24 ++
 rtl/adc_lane_shift.sv | 38 +++
 rtl/adc_multi_rx.sv | 139 +++++++++++++
 tb/tb_adc_multi_rx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_rx_pkg.sv
// Shared definitions for the multi-lane serial ADC receiver: default geometry,
// frame state encoding and a small sizing helper.
package adc_rx_pkg;

   localparam int DEF_LANES = 4;
   localparam int DEF_BITS  = 12;
   localparam int DEF_LEAD  = 2;
   localparam int DEF_QUIET = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUIET,
      S_LEAD,
      S_SHIFT,
      S_DONE
   } rx_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/adc_lane_shift.sv
// One lane's MSB-first serial-to-parallel register; data_next is the value the
// register takes on the coming edge, so a capture can happen on the final shift.
module adc_lane_shift
   import adc_rx_pkg::*;
#(
   parameter int BITS = DEF_BITS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            shift,
   input  logic            sdata,
   output logic [BITS-1:0] data_next
);

   logic [BITS-1:0] data_q;
   logic [BITS-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else if (shift) begin
         data_d = {data_q[BITS-2:0], sdata};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_next = data_d;

endmodule

// File: rtl/adc_multi_rx.sv
// Multi-lane serial ADC receiver: frames ad_cs, checks the leading-zero bits and
// deserialises LANES words per frame, single-shot or free-running.
module adc_multi_rx
   import adc_rx_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int BITS  = DEF_BITS,
   parameter int LEAD  = DEF_LEAD,
   parameter int QUIET = DEF_QUIET
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  continuous,
   input  logic                  start,
   input  logic [LANES-1:0]      ad_sdata,
   output logic                  ad_cs,
   output logic [LANES*BITS-1:0] sample,
   output logic                  sample_valid,
   output logic                  lead_err,
   output logic                  busy
);

   localparam int CW = $clog2(max3(QUIET, LEAD, BITS) + 1);
   localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET - 1);
   localparam logic [CW-1:0] LEAD_LAST  = CW'((LEAD > 0) ? LEAD - 1 : 0);
   localparam logic [CW-1:0] BITS_LAST  = CW'(BITS - 1);
   localparam rx_state_e FIRST_ACTIVE = (LEAD > 0) ? S_LEAD : S_SHIFT;

   rx_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic ad_cs_q, ad_cs_d;
   logic err_q, err_d;
   logic [LANES*BITS-1:0] sample_q, sample_d;
   logic sample_valid_q, sample_valid_d;
   logic lead_err_q, lead_err_d;
   logic lane_clear;
   logic lane_shift;
   logic capture;
   logic [LANES*BITS-1:0] lane_next;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      adc_lane_shift #(.BITS(BITS)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .clear    (lane_clear),
         .shift    (lane_shift),
         .sdata    (ad_sdata[k]),
         .data_next(lane_next[k*BITS +: BITS])
      );
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      lane_clear = 1'b0;
      lane_shift = 1'b0;
      capture    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && (continuous || start)) begin
               state_d = S_QUIET;
               cnt_d   = '0;
            end
         end
         S_QUIET: begin
            lane_clear = 1'b1;
            err_d      = 1'b0;
            if (cnt_q == QUIET_LAST) begin
               state_d = FIRST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LEAD: begin
            err_d = err_q | (|ad_sdata);
            if (cnt_q == LEAD_LAST) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            lane_shift = 1'b1;
            if (cnt_q == BITS_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = (enable && continuous) ? S_QUIET : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // ad_cs is registered from the next state so it is low exactly during LEAD/SHIFT
      ad_cs_d        = !((state_d == S_LEAD) || (state_d == S_SHIFT));
      sample_d       = capture ? lane_next : sample_q;
      lead_err_d     = capture ? err_q : lead_err_q;
      sample_valid_d = capture;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         ad_cs_q        <= 1'b1;
         err_q          <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         lead_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ad_cs_q        <= ad_cs_d;
         err_q          <= err_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         lead_err_q     <= lead_err_d;
      end
   end

   assign ad_cs        = ad_cs_q;
   assign busy         = ~ad_cs_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign lead_err     = lead_err_q;

endmodule

// File: tb/tb_adc_multi_rx.sv
// Directed bench for adc_multi_rx: default geometry plus a 2-lane/16-bit/no-lead build,
// each fed by a behavioural ADC that drives bits on the falling clock edge.
module tb_adc_multi_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        continuous = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  ad_sdata = '0;
   logic        ad_cs;
   logic [47:0] sample;
   logic        sample_valid;
   logic        lead_err;
   logic        busy;

   // LANES=2, BITS=16, LEAD=0, QUIET=1 instance
   logic        reset2 = 1'b1;
   logic        enable2 = 1'b0;
   logic        continuous2 = 1'b0;
   logic        start2 = 1'b0;
   logic [1:0]  ad_sdata2 = '0;
   logic        ad_cs2;
   logic [31:0] sample2;
   logic        sample_valid2;
   logic        lead_err2;
   logic        busy2;

   int tests_run = 0;
   int tests_failed = 0;

   logic [11:0] words [4];
   logic [3:0]  lead_mask [2];
   int          adc_cyc = 0;
   logic [15:0] words2 [2];
   int          adc_cyc2 = 0;

   adc_multi_rx dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .continuous  (continuous),
      .start       (start),
      .ad_sdata    (ad_sdata),
      .ad_cs       (ad_cs),
      .sample      (sample),
      .sample_valid(sample_valid),
      .lead_err    (lead_err),
      .busy        (busy)
   );

   adc_multi_rx #(.LANES(2), .BITS(16), .LEAD(0), .QUIET(1)) dut2 (
      .clk         (clk),
      .reset       (reset2),
      .enable      (enable2),
      .continuous  (continuous2),
      .start       (start2),
      .ad_sdata    (ad_sdata2),
      .ad_cs       (ad_cs2),
      .sample      (sample2),
      .sample_valid(sample_valid2),
      .lead_err    (lead_err2),
      .busy        (busy2)
   );

   // ADC model: two lead bits then the word MSB first, counted from ad_cs falling
   always @(negedge clk) begin
      if (ad_cs) begin
         adc_cyc  = 0;
         ad_sdata = '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (adc_cyc < 2)
               ad_sdata[k] = lead_mask[adc_cyc[0]][k];
            else if (adc_cyc < 14)
               ad_sdata[k] = words[k][4'(13 - adc_cyc)];
            else
               ad_sdata[k] = 1'b0;
         end
         adc_cyc++;
      end
   end

   always @(negedge clk) begin
      if (ad_cs2) begin
         adc_cyc2  = 0;
         ad_sdata2 = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (adc_cyc2 < 16)
               ad_sdata2[k] = words2[k][4'(15 - adc_cyc2)];
            else
               ad_sdata2[k] = 1'b0;
         end
         adc_cyc2++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // advance until sample_valid; n = cycles taken, low = cycles with ad_cs low
   task automatic run_period(input int limit, output int n, output int low,
                             output int bad, output bit seen);
      n = 0; low = 0; bad = 0; seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         if (!ad_cs) low++;
         if (busy !== !ad_cs) bad++;
         if (sample_valid) seen = 1'b1;
      end
   endtask

   task automatic run_period2(input int limit, output int n, output int low, output bit seen);
      n = 0; low = 0; seen = 1'b0;
      while (!seen && n < limit) begin
         @(negedge clk);
         n++;
         if (!ad_cs2) low++;
         if (sample_valid2) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; continuous = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (ad_cs !== 1'b1) begin tests_failed++; $display("FAIL reset_ad_cs: got %b want 1", ad_cs); end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++;
      if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      tests_run++;
      if (lead_err !== 1'b0) begin tests_failed++; $display("FAIL reset_lead_err: got %b want 0", lead_err); end
      tests_run++;
      if (sample !== 48'h0) begin tests_failed++; $display("FAIL reset_sample: got %h want 0", sample); end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if (ad_cs !== 1'b1) begin tests_failed++; $display("FAIL idle_disabled_cs: got %b want 1", ad_cs); end
   endtask

   task automatic test_continuous();
      int n, low, bad; bit seen;
      words = '{12'hA00, 12'h200, 12'hA00, 12'h200};
      lead_mask = '{4'h0, 4'h0};
      enable = 1'b1; continuous = 1'b1;
      run_period(60, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 17) begin tests_failed++; $display("FAIL cont_first_latency: got %0d (seen %b) want 17", n, seen); end
      tests_run++;
      if (low != 14) begin tests_failed++; $display("FAIL cont_cs_low: got %0d want 14", low); end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL cont_busy_vs_cs: got %0d mismatched cycles want 0", bad); end
      tests_run++;
      if (sample !== 48'h200A00200A00) begin tests_failed++; $display("FAIL cont_sample: got %h want 200a00200a00", sample); end
      tests_run++;
      if (lead_err !== 1'b0) begin tests_failed++; $display("FAIL cont_lead_err: got %b want 0", lead_err); end
      run_period(60, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 17) begin tests_failed++; $display("FAIL cont_period: got %0d (seen %b) want 17", n, seen); end
      tests_run++;
      if (low != 14) begin tests_failed++; $display("FAIL cont_cs_low2: got %0d want 14", low); end
      tests_run++;
      if (sample !== 48'h200A00200A00) begin tests_failed++; $display("FAIL cont_sample2: got %h want 200a00200a00", sample); end
   endtask

   task automatic test_lead_err();
      int n, low, bad; bit seen;
      lead_mask[1] = 4'b0100;
      run_period(60, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 17) begin tests_failed++; $display("FAIL lead_period: got %0d (seen %b) want 17", n, seen); end
      tests_run++;
      if (lead_err !== 1'b1) begin tests_failed++; $display("FAIL lead_err_set: got %b want 1", lead_err); end
      tests_run++;
      if (sample !== 48'h200A00200A00) begin tests_failed++; $display("FAIL lead_sample: got %h want 200a00200a00", sample); end
      lead_mask[1] = 4'b0000;
      @(negedge clk);
      tests_run++;
      if (lead_err !== 1'b1) begin tests_failed++; $display("FAIL lead_err_hold: got %b want 1", lead_err); end
      tests_run++;
      if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_pulse_width: got %b want 0", sample_valid); end
      run_period(60, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 16) begin tests_failed++; $display("FAIL lead_next_period: got %0d (seen %b) want 16", n, seen); end
      tests_run++;
      if (lead_err !== 1'b0) begin tests_failed++; $display("FAIL lead_err_clear: got %b want 0", lead_err); end
   endtask

   task automatic test_enable_drop();
      int n, low, bad; bit seen;
      words = '{12'h5A5, 12'h123, 12'hFFF, 12'h001};
      repeat (10) @(negedge clk);
      enable = 1'b0;
      run_period(40, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 7) begin tests_failed++; $display("FAIL endrop_completes: got %0d (seen %b) want 7", n, seen); end
      tests_run++;
      if (sample !== 48'h001FFF1235A5) begin tests_failed++; $display("FAIL endrop_sample: got %h want 001fff1235a5", sample); end
      run_period(40, n, low, bad, seen);
      tests_run++;
      if (seen || low != 0) begin tests_failed++; $display("FAIL endrop_idles: got seen %b low %0d want seen 0 low 0", seen, low); end
   endtask

   task automatic test_single_shot();
      int cs_low = 0;
      int nv = 0;
      int vat = 0;
      continuous = 1'b0; enable = 1'b1;
      words = '{12'hABC, 12'h000, 12'h800, 12'h001};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 8) start = 1'b1;
         if (i == 9) start = 1'b0;
         if (!ad_cs) cs_low++;
         if (sample_valid) begin nv++; vat = i; end
         @(negedge clk);
      end
      tests_run++;
      if (nv != 1) begin tests_failed++; $display("FAIL shot_valid_count: got %0d want 1", nv); end
      tests_run++;
      if (vat != 17) begin tests_failed++; $display("FAIL shot_frame_len: got %0d want 17", vat); end
      tests_run++;
      if (cs_low != 14) begin tests_failed++; $display("FAIL shot_cs_low: got %0d want 14", cs_low); end
      tests_run++;
      if (ad_cs !== 1'b1) begin tests_failed++; $display("FAIL shot_idle_cs: got %b want 1", ad_cs); end
      tests_run++;
      if (sample !== 48'h001800000ABC) begin tests_failed++; $display("FAIL shot_sample: got %h want 001800000abc", sample); end
   endtask

   task automatic test_reset_mid();
      int n, low, bad; bit seen;
      continuous = 1'b1;
      run_period(40, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 17) begin tests_failed++; $display("FAIL rmid_setup: got %0d (seen %b) want 17", n, seen); end
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (ad_cs !== 1'b1) begin tests_failed++; $display("FAIL rmid_cs: got %b want 1", ad_cs); end
      tests_run++;
      if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_valid: got %b want 0", sample_valid); end
      tests_run++;
      if (sample !== 48'h0) begin tests_failed++; $display("FAIL rmid_sample: got %h want 0", sample); end
      run_period(40, n, low, bad, seen);
      tests_run++;
      if (!seen || n != 17) begin tests_failed++; $display("FAIL rmid_restart: got %0d (seen %b) want 17", n, seen); end
      tests_run++;
      if (sample !== 48'h001800000ABC) begin tests_failed++; $display("FAIL rmid_sample_after: got %h want 001800000abc", sample); end
   endtask

   task automatic test_narrow_build();
      int n, low; bit seen;
      words2 = '{16'hFFFF, 16'h0001};
      tests_run++;
      if (ad_cs2 !== 1'b1 || sample2 !== 32'h0) begin
         tests_failed++; $display("FAIL n2_reset: got cs %b sample %h want cs 1 sample 0", ad_cs2, sample2);
      end
      reset2 = 1'b0; enable2 = 1'b1; continuous2 = 1'b1;
      run_period2(60, n, low, seen);
      tests_run++;
      if (!seen || n != 18) begin tests_failed++; $display("FAIL n2_first: got %0d (seen %b) want 18", n, seen); end
      tests_run++;
      if (low != 16) begin tests_failed++; $display("FAIL n2_cs_low: got %0d want 16", low); end
      tests_run++;
      if (sample2 !== 32'h0001FFFF) begin tests_failed++; $display("FAIL n2_sample: got %h want 0001ffff", sample2); end
      tests_run++;
      if (lead_err2 !== 1'b0) begin tests_failed++; $display("FAIL n2_lead_err: got %b want 0", lead_err2); end
      run_period2(60, n, low, seen);
      tests_run++;
      if (!seen || n != 18) begin tests_failed++; $display("FAIL n2_period: got %0d (seen %b) want 18", n, seen); end
      tests_run++;
      if (busy2 !== !ad_cs2) begin tests_failed++; $display("FAIL n2_busy: got %b want %b", busy2, !ad_cs2); end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_lead_err();
      test_enable_drop();
      test_single_shot();
      test_reset_mid();
      test_narrow_build();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
